// File: rtl/avmm_master_pkg.sv
// Shared types for the Avalon-MM burst master: FSM states, command record, width helper.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package avmm_master_pkg;

  // The command record is sized to cover any supported parameterisation
  // (ADDR_W <= 32, BURST_W <= 8); the top zero-extends into it and truncates out of it.
  localparam int CMD_ADDR_W = 32;
  localparam int CMD_LEN_W  = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_DATA = 3'd2,
    WR_BEAT = 3'd3,
    DONE    = 3'd4
  } state_e;

  typedef struct packed {
    logic                  write;
    logic [CMD_ADDR_W-1:0] addr;
    logic [CMD_LEN_W-1:0]  len;
  } cmd_t;

  // Width needed to hold a beat count of 0..max_burst inclusive.
  function automatic int burst_w(input int max_burst);
    return $clog2(max_burst) + 1;
  endfunction

endpackage

// File: rtl/avmm_watchdog.sv
// Stall watchdog: counts consecutive stalled cycles, flags expiry on the LIMIT-th one.
// Latency: expire is combinational in the cycle that reaches LIMIT.
// Backpressure: none; clear has priority over count_en.
// Ports: clk, reset (async, active-high), count_en (stalled this cycle),
//        clear (progress made, restart count), expire (LIMIT consecutive stalls reached).
module avmm_watchdog
  import avmm_master_pkg::*;
#(
  parameter  int LIMIT = 1024,
  localparam int CNT_W = $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic count_en,
  input  logic clear,
  output logic expire
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Fires on the stalled cycle that would make the count equal LIMIT.
  assign expire = count_en && !clear && (cnt_q == CNT_W'(LIMIT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (count_en && !expire) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (expire) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/avmm_burst_master.sv
// Avalon-MM burst master: one read/write command of 1..MAX_BURST beats per burst, done pulse at end.
// Latency: 1-beat read with no waitrequest: RD_REQ, RD_DATA (+ slave latency), DONE; rd_valid 1 cycle after readdatavalid.
// Backpressure: cmd_ready only in IDLE (no queueing); beats stall on avm_waitrequest / missing readdatavalid.
// Ports: clk, reset (async, active-high); cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_len command side;
//        wr_data/wr_pop write beat supply; rd_data/rd_valid read beats; done/error/next_addr completion;
//        avm_* Avalon-MM master interface.
// Build option: define AVMM_TIMEOUT_EN to enable the stall watchdog (TIMEOUT_CYC); otherwise error is 0.
module avmm_burst_master
  import avmm_master_pkg::*;
#(
  parameter  int ADDR_W      = 17,
  parameter  int DATA_W      = 32,
  parameter  int MAX_BURST   = 8,
  parameter  int TIMEOUT_CYC = 1024,
  localparam int BURST_W     = burst_w(MAX_BURST)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_write,
  input  logic [ADDR_W-1:0]  cmd_addr,
  input  logic [BURST_W-1:0] cmd_len,
  input  logic [DATA_W-1:0]  wr_data,
  output logic               wr_pop,
  output logic [DATA_W-1:0]  rd_data,
  output logic               rd_valid,
  output logic               done,
  output logic               error,
  output logic [ADDR_W-1:0]  next_addr,
  output logic [ADDR_W-1:0]  avm_address,
  output logic               avm_read,
  output logic               avm_write,
  output logic [DATA_W-1:0]  avm_writedata,
  output logic [BURST_W-1:0] avm_burstcount,
  input  logic               avm_waitrequest,
  input  logic [DATA_W-1:0]  avm_readdata,
  input  logic               avm_readdatavalid
);

  state_e             state_q, state_d;
  cmd_t               cmd_q, cmd_d;
  logic [BURST_W-1:0] beat_q, beat_d;
  logic [DATA_W-1:0]  rd_data_q, rd_data_d;
  logic               rd_valid_q, rd_valid_d;
  logic [ADDR_W-1:0]  next_addr_q, next_addr_d;
  logic [BURST_W-1:0] len_clamped;
  logic               last_beat;
  logic               active;

  // 0 means a single beat; anything above MAX_BURST saturates.
  always_comb begin
    len_clamped = cmd_len;
    if (cmd_len == '0) begin
      len_clamped = BURST_W'(1);
    end else if (cmd_len > BURST_W'(MAX_BURST)) begin
      len_clamped = BURST_W'(MAX_BURST);
    end
  end

  assign last_beat = (CMD_LEN_W'(beat_q) + CMD_LEN_W'(1)) == cmd_q.len;

`ifdef AVMM_TIMEOUT_EN
  logic error_q, error_d;
  logic stall;
  logic wd_expire;

  // A stall is any cycle in a bus state where the slave made no progress.
  assign stall = (((state_q == RD_REQ) || (state_q == WR_BEAT)) && avm_waitrequest) ||
                 ((state_q == RD_DATA) && !avm_readdatavalid);

  avmm_watchdog #(
    .LIMIT(TIMEOUT_CYC)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .count_en(stall),
    .clear   (!stall),
    .expire  (wd_expire)
  );
`endif

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    beat_d      = beat_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    next_addr_d = next_addr_q;
`ifdef AVMM_TIMEOUT_EN
    error_d     = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          cmd_d.write = cmd_write;
          cmd_d.addr  = CMD_ADDR_W'(cmd_addr);
          cmd_d.len   = CMD_LEN_W'(len_clamped);
          beat_d      = '0;
          state_d     = cmd_write ? WR_BEAT : RD_REQ;
        end
      end
      RD_REQ: begin
        if (!avm_waitrequest) begin
          state_d = RD_DATA;
        end
      end
      RD_DATA: begin
        if (avm_readdatavalid) begin
          rd_data_d  = avm_readdata;
          rd_valid_d = 1'b1;
          beat_d     = beat_q + BURST_W'(1);
          if (last_beat) begin
            state_d = DONE;
          end
        end
      end
      WR_BEAT: begin
        if (!avm_waitrequest) begin
          beat_d = beat_q + BURST_W'(1);
          if (last_beat) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
`ifdef AVMM_TIMEOUT_EN
    if (wd_expire) begin
      state_d = DONE;
      error_d = 1'b1;
    end
`endif
    // next_addr is valid during the done pulse so a chained command can use it directly.
    if ((state_d == DONE) && (state_q != DONE)) begin
      next_addr_d = ADDR_W'(cmd_q.addr + CMD_ADDR_W'(beat_d));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      beat_q      <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      next_addr_q <= '0;
`ifdef AVMM_TIMEOUT_EN
      error_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      beat_q      <= beat_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      next_addr_q <= next_addr_d;
`ifdef AVMM_TIMEOUT_EN
      error_q     <= error_d;
`endif
    end
  end

  // Strobes are decoded from registered state; the latched direction also gates them
  // so a request can never be issued against the wrong command type.
  assign avm_read  = (state_q == RD_REQ) && !cmd_q.write;
  assign avm_write = (state_q == WR_BEAT) && cmd_q.write;
  assign active    = avm_read || avm_write;

  assign cmd_ready      = (state_q == IDLE);
  assign avm_address    = active ? ADDR_W'(cmd_q.addr) : '0;
  assign avm_burstcount = active ? BURST_W'(cmd_q.len) : '0;
  assign avm_writedata  = avm_write ? wr_data : '0;
  assign wr_pop         = avm_write && !avm_waitrequest;
  assign rd_data        = rd_data_q;
  assign rd_valid       = rd_valid_q;
  assign done           = (state_q == DONE);
  assign next_addr      = next_addr_q;
`ifdef AVMM_TIMEOUT_EN
  assign error          = error_q;
`else
  assign error          = 1'b0;
`endif

endmodule

// File: tb/tb_avmm_burst_master.sv
// Bench for avmm_burst_master: behavioural Avalon slave with a word memory, randomized commands,
// expected data/addresses/beat counts derived from the command itself.
module tb_avmm_burst_master;

  localparam int ADDR_W    = 17;
  localparam int DATA_W    = 32;
  localparam int MAX_BURST = 8;
  localparam int BURST_W   = 4;
  localparam int TO_CYC    = 16;

  logic               clk;
  logic               reset;
  logic               cmd_valid;
  logic               cmd_ready;
  logic               cmd_write;
  logic [ADDR_W-1:0]  cmd_addr;
  logic [BURST_W-1:0] cmd_len;
  logic [DATA_W-1:0]  wr_data;
  logic               wr_pop;
  logic [DATA_W-1:0]  rd_data;
  logic               rd_valid;
  logic               done;
  logic               error;
  logic [ADDR_W-1:0]  next_addr;
  logic [ADDR_W-1:0]  avm_address;
  logic               avm_read;
  logic               avm_write;
  logic [DATA_W-1:0]  avm_writedata;
  logic [BURST_W-1:0] avm_burstcount;
  logic               avm_waitrequest;
  logic [DATA_W-1:0]  avm_readdata;
  logic               avm_readdatavalid;

  avmm_burst_master #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .MAX_BURST  (MAX_BURST),
    .TIMEOUT_CYC(TO_CYC)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_write        (cmd_write),
    .cmd_addr         (cmd_addr),
    .cmd_len          (cmd_len),
    .wr_data          (wr_data),
    .wr_pop           (wr_pop),
    .rd_data          (rd_data),
    .rd_valid         (rd_valid),
    .done             (done),
    .error            (error),
    .next_addr        (next_addr),
    .avm_address      (avm_address),
    .avm_read         (avm_read),
    .avm_write        (avm_write),
    .avm_writedata    (avm_writedata),
    .avm_burstcount   (avm_burstcount),
    .avm_waitrequest  (avm_waitrequest),
    .avm_readdata     (avm_readdata),
    .avm_readdatavalid(avm_readdatavalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Slave model state
  logic [DATA_W-1:0] mem [logic [ADDR_W-1:0]];
  int                ws_mode = 1;   // 0 random, 1 never wait, 2 toggle, 3 stuck high
  int                stall_left = 0;
  int                rdv_pct = 100;
  bit                stray_rdv = 0;
  logic [ADDR_W-1:0] rd_pend[$];
  int                wbeat = 0;
  int                pop_cnt = 0;
  int                last_bc = 0;
  bit                adv_wr = 0;
  logic [DATA_W-1:0] wq[$];
  int                widx = 0;
  int                wd_viol = 0;

  // Monitor state
  logic [DATA_W-1:0] rdq[$];
  int                done_cnt = 0;
  int                done_cyc = 0;
  logic              last_err = 0;
  logic [ADDR_W-1:0] last_next = '0;
  logic              strobe_at_done = 0;
  int                err_seen = 0;
  int                acc_cyc = 0;

  function automatic logic [DATA_W-1:0] rd_mem(input logic [ADDR_W-1:0] a);
    if (mem.exists(a)) return mem[a];
    return {15'h0, a} ^ 32'h5A5A_0000;
  endfunction

  function automatic int eff_len(input int l);
    if (l == 0) return 1;
    if (l > MAX_BURST) return MAX_BURST;
    return l;
  endfunction

  // Behavioural Avalon slave: inputs change at negedge, handshakes observed 1ns later.
  initial begin
    logic [ADDR_W-1:0] wa;
    avm_waitrequest   = 1'b0;
    avm_readdatavalid = 1'b0;
    avm_readdata      = '0;
    forever begin
      @(negedge clk);
      if (adv_wr) begin
        widx++;
        wr_data = (widx < wq.size()) ? wq[widx] : '0;
        adv_wr  = 0;
      end
      if (stray_rdv) begin
        avm_readdatavalid = 1'b1;
        avm_readdata      = $urandom;
      end else if (rd_pend.size() > 0 && $urandom_range(99) < rdv_pct) begin
        avm_readdatavalid = 1'b1;
        avm_readdata      = rd_mem(rd_pend.pop_front());
      end else begin
        avm_readdatavalid = 1'b0;
        avm_readdata      = $urandom;
      end
      if ((avm_read || avm_write) && stall_left > 0) begin
        avm_waitrequest = 1'b1;
        stall_left--;
      end else begin
        case (ws_mode)
          0: avm_waitrequest = ($urandom_range(2) == 0);
          2: avm_waitrequest = ~avm_waitrequest;
          3: avm_waitrequest = 1'b1;
          default: avm_waitrequest = 1'b0;
        endcase
      end
      #1;
      if (avm_write) last_bc = int'(avm_burstcount);
      if (avm_write && !avm_waitrequest) begin
        wa = avm_address + ADDR_W'(wbeat);
        mem[wa] = avm_writedata;
        wbeat++;
        if (wbeat >= int'(avm_burstcount)) wbeat = 0;
      end
      if (wr_pop) begin
        pop_cnt++;
        adv_wr = 1;
      end
      if (avm_read && !avm_waitrequest) begin
        last_bc = int'(avm_burstcount);
        for (int i = 0; i < int'(avm_burstcount); i++) rd_pend.push_back(avm_address + ADDR_W'(i));
      end
      if (!avm_write && avm_writedata != '0) wd_viol++;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rd_valid) rdq.push_back(rd_data);
      if (error && !done) err_seen++;
      if (done) begin
        done_cnt++;
        done_cyc       = cyc;
        last_err       = error;
        last_next      = next_addr;
        strobe_at_done = avm_read | avm_write;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, got time %0t required < 500000", $time);
    $fatal(1);
  end

  task automatic issue(input logic w, input logic [ADDR_W-1:0] a, input logic [BURST_W-1:0] l);
    @(negedge clk);
    #3;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL cmd_ready_idle: got %b expected 1", cmd_ready);
    end
    rd_pend.delete();
    wbeat     = 0;
    cmd_write = w;
    cmd_addr  = a;
    cmd_len   = l;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    acc_cyc   = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int d0;
    d0 = done_cnt;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #3;
      if (done_cnt != d0) begin
        ok = 1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL done_timeout: got no done within %0d cycles expected done", budget);
    end
  endtask

  task automatic check_end(input logic [ADDR_W-1:0] a, input int n);
    logic [ADDR_W-1:0] exp_next;
    exp_next = a + ADDR_W'(n);
    checks++;
    if (last_next !== exp_next) begin
      errors++;
      $display("FAIL next_addr: got %05h expected %05h", last_next, exp_next);
    end
    checks++;
    if (last_bc != n) begin
      errors++;
      $display("FAIL burstcount: got %0d expected %0d", last_bc, n);
    end
    checks++;
    if (last_err !== 1'b0) begin
      errors++;
      $display("FAIL error_flag: got %b expected 0", last_err);
    end
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] a, input logic [BURST_W-1:0] l);
    bit ok;
    int n;
    n = eff_len(int'(l));
    rdq.delete();
    issue(1'b0, a, l);
    wait_done(400, ok);
    checks++;
    if (rdq.size() != n) begin
      errors++;
      $display("FAIL rd_beats: got %0d expected %0d", rdq.size(), n);
    end
    for (int i = 0; i < n && i < rdq.size(); i++) begin
      checks++;
      if (rdq[i] !== rd_mem(a + ADDR_W'(i))) begin
        errors++;
        $display("FAIL rd_data[%0d]: got %08h expected %08h", i, rdq[i], rd_mem(a + ADDR_W'(i)));
      end
    end
    check_end(a, n);
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [BURST_W-1:0] l);
    bit ok;
    int n, p0;
    n = eff_len(int'(l));
    wq.delete();
    for (int i = 0; i < n; i++) wq.push_back($urandom);
    widx    = 0;
    wr_data = wq[0];
    p0      = pop_cnt;
    issue(1'b1, a, l);
    wait_done(400, ok);
    checks++;
    if (pop_cnt - p0 != n) begin
      errors++;
      $display("FAIL wr_pop_count: got %0d expected %0d", pop_cnt - p0, n);
    end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (rd_mem(a + ADDR_W'(i)) !== wq[i]) begin
        errors++;
        $display("FAIL wr_mem[%0d]: got %08h expected %08h", i, rd_mem(a + ADDR_W'(i)), wq[i]);
      end
    end
    check_end(a, n);
  endtask

  task automatic test_reset();
    logic [63:0] obs;
    reset = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0; wr_data = '0;
    repeat (3) @(negedge clk);
    #3;
    obs = {cmd_ready, avm_read, avm_write, done, error, rd_valid, wr_pop, 57'h0};
    checks++;
    if (obs !== {1'b1, 6'b0, 57'h0}) begin
      errors++;
      $display("FAIL reset_ctrl: got %h expected %h", obs[63:57], 7'b1000000);
    end
    checks++;
    if ({next_addr, avm_address, avm_burstcount, rd_data, avm_writedata} !== '0) begin
      errors++;
      $display("FAIL reset_data: got %05h/%05h/%0h/%08h/%08h expected all 0",
               next_addr, avm_address, avm_burstcount, rd_data, avm_writedata);
    end
    reset = 1'b0;
  endtask

  task automatic test_read_basic();
    for (int i = 0; i < 4; i++) mem[17'h00100 + ADDR_W'(i)] = 32'hA0 + i;
    ws_mode = 1; rdv_pct = 100; stall_left = 2;
    do_read(17'h00100, 4'd4);
  endtask

  task automatic test_write_wrap();
    ws_mode = 2;
    do_write(17'h1FFFE, 4'd3);
    ws_mode = 1;
  endtask

  task automatic test_len_clamp();
    ws_mode = 0; rdv_pct = 60;
    do_read(ADDR_W'($urandom), 4'd0);
    do_write(ADDR_W'($urandom), 4'd15);
    do_read(ADDR_W'($urandom), 4'd9);
  endtask

  task automatic test_busy_ignored();
    bit ok;
    int d0, wcnt;
    ws_mode = 1; rdv_pct = 30; stall_left = 3;
    rdq.delete();
    d0 = done_cnt;
    issue(1'b0, 17'h00040, 4'd4);
    wcnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #3;
      cmd_write = 1'b1; cmd_addr = 17'h00999; cmd_len = 4'd2; cmd_valid = 1'b1;
      if (cmd_ready) wcnt++;
    end
    cmd_valid = 1'b0;
    checks++;
    if (wcnt != 0) begin
      errors++;
      $display("FAIL busy_ready: got cmd_ready high %0d cycles expected 0", wcnt);
    end
    wait_done(400, ok);
    repeat (6) @(negedge clk);
    #3;
    checks++;
    if (done_cnt - d0 != 1 || rdq.size() != 4) begin
      errors++;
      $display("FAIL busy_ignored: got %0d done/%0d beats expected 1 done/4 beats", done_cnt - d0, rdq.size());
    end
  endtask

  task automatic test_reset_mid_burst();
    int d0;
    ws_mode = 1; rdv_pct = 40;
    rdq.delete();
    d0 = done_cnt;
    issue(1'b0, 17'h00200, 4'd4);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      #3;
      if (rdq.size() >= 2) break;
    end
    checks++;
    if (rdq.size() != 2) begin
      errors++;
      $display("FAIL mid_beats: got %0d expected 2", rdq.size());
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({cmd_ready, avm_read, avm_write, rd_valid, done} !== 5'b10000 || next_addr !== '0) begin
      errors++;
      $display("FAIL mid_reset: got ctrl %b next %05h expected 10000 next 00000",
               {cmd_ready, avm_read, avm_write, rd_valid, done}, next_addr);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    stray_rdv = 1;
    repeat (4) @(negedge clk);
    stray_rdv = 0;
    rd_pend.delete();
    repeat (2) @(negedge clk);
    #3;
    checks++;
    if (rdq.size() != 2 || done_cnt != d0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL stray_rdv: got %0d beats %0d done ready %b expected 2 beats 0 done ready 1",
               rdq.size(), done_cnt - d0, cmd_ready);
    end
  endtask

  task automatic test_random();
    ws_mode = 0; rdv_pct = 60;
    for (int k = 0; k < 20; k++) begin
      logic [ADDR_W-1:0] a;
      logic [BURST_W-1:0] l;
      a = 17'h1FFF0 + ADDR_W'($urandom_range(0, 31));
      l = BURST_W'($urandom_range(0, 15));
      if ($urandom_range(1)) do_write(a, l);
      else do_read(a, l);
    end
    checks++;
    if (wd_viol != 0) begin
      errors++;
      $display("FAIL writedata_idle: got %0d nonzero cycles expected 0", wd_viol);
    end
  endtask

  task automatic test_back_to_back();
    int d;
    ws_mode = 1; rdv_pct = 100;
    do_read(17'h00300, 4'd1);
    d = done_cyc;
    do_write(last_next, 4'd1);
    checks++;
    if (acc_cyc != d + 2) begin
      errors++;
      $display("FAIL b2b_accept: got accept %0d cycles after done expected 1", acc_cyc - d - 1);
    end
  endtask

`ifdef AVMM_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    ws_mode = 3;
    issue(1'b0, 17'h00500, 4'd4);
    wait_done(100, ok);
    checks++;
    if (done_cyc - acc_cyc != TO_CYC || last_err !== 1'b1 || strobe_at_done !== 1'b0 || last_next !== 17'h00500) begin
      errors++;
      $display("FAIL timeout_req: got dt %0d err %b strobe %b next %05h expected %0d 1 0 00500",
               done_cyc - acc_cyc, last_err, strobe_at_done, last_next, TO_CYC);
    end
    ws_mode = 1; rdv_pct = 0;
    issue(1'b0, 17'h00600, 4'd2);
    wait_done(100, ok);
    checks++;
    if (last_err !== 1'b1 || last_next !== 17'h00600) begin
      errors++;
      $display("FAIL timeout_data: got err %b next %05h expected 1 00600", last_err, last_next);
    end
    rdv_pct = 100;
    rd_pend.delete();
    @(negedge clk);
  endtask
`else
  task automatic test_no_error();
    checks++;
    if (err_seen != 0 || error !== 1'b0) begin
      errors++;
      $display("FAIL error_tied: got %0d error cycles expected 0", err_seen);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_read_basic();
    test_write_wrap();
    test_len_clamp();
    test_busy_ignored();
    test_reset_mid_burst();
    test_random();
    test_back_to_back();
`ifdef AVMM_TIMEOUT_EN
    test_timeout();
`else
    test_no_error();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
